// File: rtl/restador_serial_ctrl_pkg.sv
// Shared types and constants for the bit-serial subtraction controller.
package restador_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} estado_t;

    localparam int unsigned N_DEF = 4;

endpackage

// File: rtl/restador_serial_ctrl_if.sv
// Start/operand/result bundle between the operand logic and the serial subtractor.
interface restador_serial_ctrl_if
    import restador_pkg::*;
#(
    parameter int unsigned N = N_DEF
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] resultado;
    logic         borrow;

    modport master (
        output start, a, b, bin,
        input  busy, done, resultado, borrow
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, resultado, borrow
    );
endinterface

// File: rtl/restador_serial_ctrl_restador1bit.sv
// One-bit full subtractor cell: difference and borrow-out of A - B - Cin.
module Restador1Bit (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic resta,
    output logic Cout
);
    assign resta = A ^ B ^ Cin;
    assign Cout  = (~A & B) | (~(A ^ B) & Cin);
endmodule

// File: rtl/restador_serial_ctrl.sv
// Sequences one Restador1Bit cell LSB first to form (a - b - bin) mod 2^N,
// recirculating the borrow through a register and pulsing done when finished.
module restador_serial_ctrl
    import restador_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    restador_serial_ctrl_if.slave bus
);
    localparam int unsigned IDXW = $clog2(N);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

    estado_t         state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            brw_q, brw_d;
    logic [N-1:0]    part_q, part_d;
    logic [N-1:0]    res_q, res_d;
    logic            borrow_q, borrow_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic cell_a_c, cell_b_c, resta_c, cout_c;

    assign cell_a_c = a_q[idx_q];
    assign cell_b_c = b_q[idx_q];

    Restador1Bit u_cell (
        .A     (cell_a_c),
        .B     (cell_b_c),
        .Cin   (brw_q),
        .resta (resta_c),
        .Cout  (cout_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            brw_q    <= 1'b0;
            part_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            brw_q    <= brw_d;
            part_q   <= part_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        brw_d    = brw_q;
        part_d   = part_q;
        res_d    = res_q;
        borrow_d = borrow_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.bin;
                    idx_d   = '0;
                    part_d  = '0;
                end
            end
            RUN: begin
                part_d[idx_q] = resta_c;
                brw_d         = cout_c;
                // Last bit: publish result and final borrow together.
                if (idx_q == IDX_LAST) begin
                    state_d  = DONE;
                    res_d    = part_d;
                    borrow_d = cout_c;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.resultado = res_q;
    assign bus.borrow    = borrow_q;
endmodule
